// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: per-register cycles-until-forwardable countdowns driving stall/bubble.
// Optional stall/flush cycle counters are enabled with `define HAZARD_STALL_STATS_EN.
module hazard_scoreboard #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       id_valid_i,
    input  logic [4:0] id_rsaddr_i,
    input  logic [4:0] id_rtaddr_i,
    input  logic       id_rs_used_i,
    input  logic       id_rt_used_i,
    input  logic       id_wb_i,
    input  logic [4:0] id_writeaddr_i,
    input  logic [1:0] id_lat_i,
    input  logic       flush_i,
    output logic       stall_o,
    output logic       ifid_write_o,
    output logic       idex_bubble_o,
    output logic       busy_o
`ifdef HAZARD_STALL_STATS_EN
    ,
    output logic [15:0] stall_cnt_o,
    output logic [15:0] flush_cnt_o
`endif
);

    localparam int unsigned NREG  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned STATW = 16;
    localparam logic [1:0]  LAT_LOAD = 2'b01;
    localparam logic [1:0]  LAT_MUL  = 2'b10;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];

    logic [CNT_W-1:0] issue_val_c;
    logic [CNT_W-1:0] rs_cnt_c;
    logic [CNT_W-1:0] rt_cnt_c;
    logic [CNT_W-1:0] wr_cnt_c;
    logic             raw_c;
    logic             waw_c;
    logic             stall_c;
    logic             issue_c;
    logic             busy_c;

    // Hazard detection and issue decision for the instruction sitting in ID.
    always_comb begin
        issue_val_c = '0;
        case (id_lat_i)
            LAT_LOAD: issue_val_c = CNT_W'(1);
            LAT_MUL:  issue_val_c = CNT_W'(MUL_LAT - 1);
            default:  issue_val_c = '0;
        endcase

        rs_cnt_c = cnt_q[id_rsaddr_i];
        rt_cnt_c = cnt_q[id_rtaddr_i];
        wr_cnt_c = cnt_q[id_writeaddr_i];

        raw_c = id_valid_i &
                ((id_rs_used_i & (id_rsaddr_i != '0) & (rs_cnt_c != '0)) |
                 (id_rt_used_i & (id_rtaddr_i != '0) & (rt_cnt_c != '0)));
        // A younger write must not retire ahead of an older, slower one.
        waw_c = id_valid_i & id_wb_i & (id_writeaddr_i != '0) & (wr_cnt_c > issue_val_c);

        stall_c = (raw_c | waw_c) & ~flush_i;
        issue_c = id_valid_i & id_wb_i & (id_writeaddr_i != '0) & ~stall_c & ~flush_i;
    end

    // Countdown update: a fresh issue overrides the decrement on its own register.
    always_comb begin
        busy_c   = 1'b0;
        cnt_d[0] = '0;
        for (int unsigned r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (issue_c && (id_writeaddr_i == AW'(r))) begin
                cnt_d[r] = issue_val_c;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
            busy_c = busy_c | (cnt_q[r] != '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    assign stall_o       = stall_c;
    assign ifid_write_o  = ~stall_c;
    assign idex_bubble_o = stall_c;
    assign busy_o        = busy_c;

`ifdef HAZARD_STALL_STATS_EN
    logic [STATW-1:0] stall_cnt_q;
    logic [STATW-1:0] stall_cnt_d;
    logic [STATW-1:0] flush_cnt_q;
    logic [STATW-1:0] flush_cnt_d;

    // Saturating event counters.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_c && (stall_cnt_q != {STATW{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + STATW'(1);
        end
        if (flush_i && (flush_cnt_q != {STATW{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + STATW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: MUL_LAT=3 instance (a) and MUL_LAT=5 instance (b) on shared inputs.
module tb_hazard_scoreboard;

    localparam logic [1:0] ALU  = 2'b00;
    localparam logic [1:0] LOAD = 2'b01;
    localparam logic [1:0] MUL  = 2'b10;
    localparam logic [1:0] RSV  = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [4:0] id_rsaddr;
    logic [4:0] id_rtaddr;
    logic       id_rs_used;
    logic       id_rt_used;
    logic       id_wb;
    logic [4:0] id_writeaddr;
    logic [1:0] id_lat;
    logic       flush;

    logic stall_a, ifid_a, bubble_a, busy_a;
    logic stall_b, ifid_b, bubble_b, busy_b;
`ifdef HAZARD_STALL_STATS_EN
    logic [15:0] stall_cnt_a, flush_cnt_a, stall_cnt_b, flush_cnt_b;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MUL_LAT(3), .CNT_W(3)) dut_a (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rsaddr_i(id_rsaddr), .id_rtaddr_i(id_rtaddr),
        .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .id_wb_i(id_wb), .id_writeaddr_i(id_writeaddr), .id_lat_i(id_lat),
        .flush_i(flush), .stall_o(stall_a), .ifid_write_o(ifid_a),
        .idex_bubble_o(bubble_a), .busy_o(busy_a)
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cnt_o(stall_cnt_a), .flush_cnt_o(flush_cnt_a)
`endif
    );

    hazard_scoreboard #(.MUL_LAT(5), .CNT_W(3)) dut_b (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rsaddr_i(id_rsaddr), .id_rtaddr_i(id_rtaddr),
        .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .id_wb_i(id_wb), .id_writeaddr_i(id_writeaddr), .id_lat_i(id_lat),
        .flush_i(flush), .stall_o(stall_b), .ifid_write_o(ifid_b),
        .idex_bubble_o(bubble_b), .busy_o(busy_b)
`ifdef HAZARD_STALL_STATS_EN
        , .stall_cnt_o(stall_cnt_b), .flush_cnt_o(flush_cnt_b)
`endif
    );

    task automatic idle();
        id_valid = 1'b0; id_rsaddr = '0; id_rtaddr = '0;
        id_rs_used = 1'b0; id_rt_used = 1'b0;
        id_wb = 1'b0; id_writeaddr = '0; id_lat = ALU; flush = 1'b0;
    endtask

    task automatic instr(input logic [4:0] rs, input logic rsu, input logic [4:0] rt,
                         input logic rtu, input logic wb, input logic [4:0] wa,
                         input logic [1:0] lat);
        id_valid = 1'b1; id_rsaddr = rs; id_rs_used = rsu; id_rtaddr = rt;
        id_rt_used = rtu; id_wb = wb; id_writeaddr = wa; id_lat = lat; flush = 1'b0;
    endtask

    // Inputs change just after a falling edge; outputs are sampled 1ns later.
    task automatic do_reset();
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL reset_stall cyc=%0d got=%b exp=0", k, stall_a); end
            checks++; if (ifid_a !== 1'b1) begin failures++; $display("FAIL reset_ifid cyc=%0d got=%b exp=1", k, ifid_a); end
            checks++; if (bubble_a !== 1'b0) begin failures++; $display("FAIL reset_bubble cyc=%0d got=%b exp=0", k, bubble_a); end
            checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", k, busy_a); end
            @(negedge clk);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, LOAD);
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL lu_issue_stall got=%b exp=0", stall_a); end
        @(negedge clk);
        instr(5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd14, ALU);
        #1;
        checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL lu_stall got=%b exp=1", stall_a); end
        checks++; if (ifid_a !== 1'b0) begin failures++; $display("FAIL lu_ifid got=%b exp=0", ifid_a); end
        checks++; if (bubble_a !== 1'b1) begin failures++; $display("FAIL lu_bubble got=%b exp=1", bubble_a); end
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL lu_busy got=%b exp=1", busy_a); end
        @(negedge clk);
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL lu_release got=%b exp=0", stall_a); end
        checks++; if (ifid_a !== 1'b1) begin failures++; $display("FAIL lu_release_ifid got=%b exp=1", ifid_a); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL lu_drained_busy got=%b exp=0", busy_a); end
        @(negedge clk);
    endtask

    task automatic test_alu_forward();
        do_reset();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, ALU);
        @(negedge clk);
        instr(5'd0, 1'b0, 5'd9, 1'b1, 1'b1, 5'd16, ALU);
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL alu_fwd_stall got=%b exp=0", stall_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL alu_fwd_busy got=%b exp=0", busy_a); end
        @(negedge clk);
        idle();
    endtask

    // Holds a dependent read of $10 until the chosen instance stops stalling (bounded).
    task automatic test_mul();
        int n;
        for (int sel = 0; sel < 2; sel++) begin
            do_reset();
            instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, MUL);
            @(negedge clk);
            instr(5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd17, ALU);
            n = 0;
            for (int k = 0; k < 10; k++) begin
                #1;
                if ((sel == 0) ? stall_a : stall_b) n++;
                else break;
                @(negedge clk);
            end
            checks++;
            if (n !== ((sel == 0) ? 2 : 4)) begin
                failures++;
                $display("FAIL mul_stall_cycles lat=%0d got=%0d exp=%0d", (sel == 0) ? 3 : 5, n, (sel == 0) ? 2 : 4);
            end
            @(negedge clk);
            idle();
        end
    endtask

    task automatic test_waw();
        do_reset();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, MUL);
        @(negedge clk);
        idle();
        @(negedge clk);
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, ALU);
        #1;
        checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL waw_alu_stall got=%b exp=1", stall_a); end
        @(negedge clk);
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL waw_alu_release got=%b exp=0", stall_a); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL waw_alu_busy got=%b exp=0", busy_a); end
        // LOAD behind MUL: cnt=2 > 1 stalls, cnt=1 > 1 does not.
        do_reset();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, MUL);
        @(negedge clk);
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11, LOAD);
        #1;
        checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL waw_load_stall got=%b exp=1", stall_a); end
        @(negedge clk);
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL waw_load_release got=%b exp=0", stall_a); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_a !== 1'b1) begin failures++; $display("FAIL waw_load_busy got=%b exp=1", busy_a); end
        @(negedge clk);
        #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL waw_load_drain got=%b exp=0", busy_a); end
    endtask

    task automatic test_reg0();
        do_reset();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, LOAD);
        @(negedge clk);
        instr(5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, ALU);
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL reg0_stall got=%b exp=0", stall_a); end
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL reg0_busy got=%b exp=0", busy_a); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_flush();
        do_reset();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, LOAD);
        @(negedge clk);
        instr(5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 5'd13, LOAD);
        flush = 1'b1;
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL flush_stall got=%b exp=0", stall_a); end
        checks++; if (ifid_a !== 1'b1) begin failures++; $display("FAIL flush_ifid got=%b exp=1", ifid_a); end
        checks++; if (bubble_a !== 1'b0) begin failures++; $display("FAIL flush_bubble got=%b exp=0", bubble_a); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (busy_a !== 1'b0) begin failures++; $display("FAIL flush_no_issue got=%b exp=0", busy_a); end
    endtask

    task automatic test_reserved_lat();
        do_reset();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd15, RSV);
        @(negedge clk);
        instr(5'd15, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, ALU);
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL rsv_lat_stall got=%b exp=0", stall_a); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, MUL);
        @(negedge clk);
        instr(5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, ALU);
        #1;
        checks++; if (stall_b !== 1'b1) begin failures++; $display("FAIL mid_pre_stall got=%b exp=1", stall_b); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (stall_b !== 1'b0) begin failures++; $display("FAIL mid_post_stall got=%b exp=0", stall_b); end
        checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL mid_post_busy got=%b exp=0", busy_b); end
        @(negedge clk);
        idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd20, LOAD);
        @(negedge clk);
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd21, LOAD);
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL b2b_second_load got=%b exp=0", stall_a); end
        @(negedge clk);
        instr(5'd20, 1'b1, 5'd21, 1'b1, 1'b0, 5'd0, ALU);
        #1;
        checks++; if (stall_a !== 1'b1) begin failures++; $display("FAIL b2b_rt_stall got=%b exp=1", stall_a); end
        @(negedge clk);
        #1;
        checks++; if (stall_a !== 1'b0) begin failures++; $display("FAIL b2b_release got=%b exp=0", stall_a); end
        @(negedge clk);
        idle();
    endtask

`ifdef HAZARD_STALL_STATS_EN
    task automatic test_stats();
        do_reset();
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, LOAD);
        @(negedge clk);
        instr(5'd8, 1'b1, 5'd0, 1'b0, 1'b1, 5'd14, ALU);
        @(negedge clk);
        @(negedge clk);
        instr(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, LOAD);
        @(negedge clk);
        instr(5'd12, 1'b1, 5'd0, 1'b0, 1'b1, 5'd13, LOAD);
        flush = 1'b1;
        @(negedge clk);
        idle();
        #1;
        checks++; if (stall_cnt_a !== 16'd1) begin failures++; $display("FAIL stats_stall got=%0d exp=1", stall_cnt_a); end
        checks++; if (flush_cnt_a !== 16'd1) begin failures++; $display("FAIL stats_flush got=%0d exp=1", flush_cnt_a); end
        do_reset();
        #1;
        checks++; if (stall_cnt_a !== 16'd0) begin failures++; $display("FAIL stats_reset got=%0d exp=0", stall_cnt_a); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        idle();
        @(negedge clk);
        test_reset();
        test_load_use();
        test_alu_forward();
        test_mul();
        test_waw();
        test_reg0();
        test_flush();
        test_reserved_lat();
        test_reset_mid_stall();
        test_back_to_back();
`ifdef HAZARD_STALL_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
